// File: rtl/multicyc_mem_port_pkg.sv
// MemPortPkg: shared types and constants for the multicycle CPU memory port.
//   state_e     - port FSM states (IDLE, WAIT, DONE)
//   Fault*      - codes reported on the sticky fault output
//   is_aligned  - word-alignment test on the two low address bits
package MemPortPkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] FaultNone     = 2'b00;
    localparam logic [1:0] FaultMisalign = 2'b01;
    localparam logic [1:0] FaultTimeout  = 2'b10;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/multicyc_mem_port_timeout_ctr.sv
// mem_timeout_ctr: counts WAIT cycles spent without a memory acknowledge.
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - restart the count from zero (entering WAIT)
//   enable      - advance the count (WAIT cycle with no ack)
//   expire      - count has reached TIMEOUT-1, the last allowed WAIT cycle
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // Wrap on the expiring cycle is harmless: the FSM leaves WAIT and
            // the next transaction clears the count.
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LastCnt);

endmodule

// File: rtl/multicyc_mem_port.sv
// multicyc_mem_port: adapter between the multicycle CPU and a variable-latency
// req/ack memory. One CPU access is latched, held on the memory side until
// acknowledged or timed out, and the controller is stalled meanwhile.
//   clk, reset           - clock, asynchronous active-high reset
//   cpu_rd, cpu_wr       - request levels, held by the CPU while cpu_stall=1
//   cpu_addr, cpu_wdata  - byte address and write data
//   cpu_rdata            - read data hold register (updates only on acked read)
//   cpu_stall            - controller must not advance while high
//   mem_req/we/addr/wdata- registered memory request
//   mem_ack, mem_rdata   - one-cycle acknowledge and its read data
//   fault, fault_clr     - sticky first fault (01 misaligned, 10 timeout), clear
module multicyc_mem_port
    import MemPortPkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        fault,
    input  logic              fault_clr
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        fault_q, fault_d;

    logic       cpu_req;
    logic       start;
    logic       raise;
    logic [1:0] raise_code;
    logic       expire;

    assign cpu_req = cpu_rd | cpu_wr;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .enable ((state_q == WAIT) && !mem_ack),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        start       = 1'b0;
        raise       = 1'b0;
        raise_code  = FaultNone;
        cpu_stall   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cpu_stall = cpu_req;
                if (cpu_req) begin
                    if (is_aligned(cpu_addr[1:0])) begin
                        start       = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_wr;  // rd and wr together means write
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        state_d     = WAIT;
                    end else begin
                        raise      = 1'b1;
                        raise_code = FaultMisalign;
                        state_d    = DONE;
                    end
                end
            end
            WAIT: begin
                cpu_stall = 1'b1;
                // Ack wins over timeout on the last allowed cycle.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (expire) begin
                    mem_req_d  = 1'b0;
                    raise      = 1'b1;
                    raise_code = FaultTimeout;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // Held request levels are ignored here so nothing is reissued.
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Only the first fault sticks; a fault arriving with a clear is kept.
        fault_d = fault_q;
        if (fault_clr) begin
            fault_d = FaultNone;
        end
        if (raise && (fault_q == FaultNone || fault_clr)) begin
            fault_d = raise_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            fault_q     <= FaultNone;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = rdata_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_multicyc_mem_port.sv
// Self-checking bench for multicyc_mem_port: directed cases from the test plan
// followed by randomized transactions, all checked against a transaction-level
// model (expected stall/request lengths, read data and sticky fault).
module tb_multicyc_mem_port;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        fault;
    logic              fault_clr;

    multicyc_mem_port #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [31:0] exp_rdata;
    logic [1:0]  exp_fault;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call #1 after a rising edge with the DUT idle. ack_delay is the WAIT-cycle
    // index (0-based) at which mem_ack is given; >= TIMEOUT means never.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_delay,
                           input logic [31:0] rdata, input logic clr, input logic late_ack);
        int          stall_cycles;
        int          req_cycles;
        int          wait_idx;
        int          guard;
        logic        done;
        int          exp_stall;
        int          exp_req;
        logic [31:0] next_rdata;
        logic [1:0]  next_fault;

        stall_cycles = 0;
        req_cycles   = 0;
        wait_idx     = 0;
        guard        = 0;
        done         = 1'b0;

        // Expected outcome straight from the port's rules.
        next_rdata = exp_rdata;
        next_fault = clr ? 2'b00 : exp_fault;
        if (addr[1:0] != 2'b00) begin
            exp_stall = 1;
            exp_req   = 0;
            if (next_fault == 2'b00) next_fault = 2'b01;
        end else if (ack_delay <= int'(TIMEOUT) - 1) begin
            exp_stall = ack_delay + 2;
            exp_req   = ack_delay + 1;
            if (!wr) next_rdata = rdata;
        end else begin
            exp_stall = int'(TIMEOUT) + 1;
            exp_req   = int'(TIMEOUT);
            if (next_fault == 2'b00) next_fault = 2'b10;
        end

        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        fault_clr = clr;

        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                req_cycles++;
                check_eq("wait_mem_we", 64'(mem_we), 64'(wr));
                check_eq("wait_mem_addr", 64'(mem_addr), 64'(addr));
                check_eq("wait_mem_wdata", 64'(mem_wdata), 64'(wdata));
                if (wait_idx == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                wait_idx++;
            end
            if (cpu_stall) begin
                stall_cycles++;
            end else begin
                done = 1'b1;
                check_eq("done_cpu_rdata", 64'(cpu_rdata), 64'(next_rdata));
                check_eq("done_fault", 64'(fault), 64'(next_fault));
                check_eq("done_mem_req", 64'(mem_req), 64'(0));
                if (late_ack) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ~next_rdata;
                end
            end
            @(posedge clk);
            #1;
            fault_clr = 1'b0;
        end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;

        check_eq("txn_completes", 64'(done), 64'(1));
        check_eq("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        check_eq("req_cycles", 64'(req_cycles), 64'(exp_req));

        if (late_ack) begin
            // Ack stays high through one IDLE edge as well.
            @(posedge clk);
            #1;
            check_eq("late_ack_rdata", 64'(cpu_rdata), 64'(next_rdata));
            check_eq("late_ack_req", 64'(mem_req), 64'(0));
            check_eq("late_ack_stall", 64'(cpu_stall), 64'(0));
            mem_ack = 1'b0;
        end

        exp_rdata = next_rdata;
        exp_fault = next_fault;
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        exp_fault = 2'b00;
        check_eq("fault_cleared", 64'(fault), 64'(0));
    endtask

    initial begin
        reset     = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        fault_clr = 1'b0;
        exp_rdata = '0;
        exp_fault = 2'b00;

        #1;
        check_eq("rst_mem_req", 64'(mem_req), 64'(0));
        check_eq("rst_mem_we", 64'(mem_we), 64'(0));
        check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
        check_eq("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("rst_fault", 64'(fault), 64'(0));
        check_eq("rst_stall", 64'(cpu_stall), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Read, ack on the 3rd WAIT cycle.
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
        // Write, ack in the first WAIT cycle.
        run_txn(1'b0, 1'b1, 32'h204, 32'h12345678, 0, 32'h0F0F0F0F, 1'b0, 1'b0);
        // Misaligned read, then a timeout that must not overwrite the fault.
        run_txn(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h11111111, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h108, 32'h0, TIMEOUT + 2, 32'h22222222, 1'b0, 1'b0);
        clear_fault();
        // Timeout with a late ack in DONE and IDLE.
        run_txn(1'b1, 1'b0, 32'h10C, 32'h0, TIMEOUT + 2, 32'h33333333, 1'b0, 1'b1);
        clear_fault();
        // Ack on the last allowed WAIT cycle.
        run_txn(1'b1, 1'b0, 32'h110, 32'h0, TIMEOUT - 1, 32'hCAFEF00D, 1'b0, 1'b0);
        // Both levels high: write, read data must hold.
        run_txn(1'b1, 1'b1, 32'h114, 32'hA5A5A5A5, 1, 32'h44444444, 1'b0, 1'b0);
        // Timeout fault, then a misaligned access with a simultaneous clear.
        run_txn(1'b0, 1'b1, 32'h118, 32'h5, TIMEOUT + 1, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h11B, 32'h6, 0, 32'h0, 1'b1, 1'b0);

        // Reset in the middle of WAIT.
        cpu_rd    = 1'b1;
        cpu_addr  = 32'h300;
        cpu_wdata = 32'hAAAA5555;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_req", 64'(mem_req), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_mem_req", 64'(mem_req), 64'(0));
        check_eq("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check_eq("midrst_mem_wdata", 64'(mem_wdata), 64'(0));
        check_eq("midrst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("midrst_fault", 64'(fault), 64'(0));
        check_eq("midrst_stall", 64'(cpu_stall), 64'(1));
        cpu_rd    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_ack_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("post_rst_ack_req", 64'(mem_req), 64'(0));
        check_eq("post_rst_ack_stall", 64'(cpu_stall), 64'(0));
        mem_ack   = 1'b0;
        exp_rdata = '0;
        exp_fault = 2'b00;
        run_txn(1'b1, 1'b0, 32'h300, 32'hAAAA5555, 1, 32'h0BADF00D, 1'b0, 1'b0);

        // Randomized transactions.
        for (int i = 0; i < 30; i++) begin
            logic        r_rd;
            logic        r_wr;
            logic [31:0] r_addr;
            r_rd   = 1'($urandom_range(0, 1));
            r_wr   = r_rd ? 1'($urandom_range(0, 1)) : 1'b1;
            r_addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
            run_txn(r_rd, r_wr, r_addr, $urandom, int'($urandom_range(0, TIMEOUT + 1)),
                    $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicyc_mem_port.md
# multicyc_mem_port

Bus adapter between the multicycle CPU (controller plus datapath) and a variable-latency memory with a request/acknowledge handshake. It latches one CPU read or write, holds it on the memory side until acknowledged, and returns read data in a hold register. It stalls the controller's state register for the whole transaction. Misaligned accesses and unanswered requests are reported as sticky faults.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles without ack before a timeout fault (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_rd  in  1  read request level, held while cpu_stall=1
- cpu_wr  in  1  write request level, held while cpu_stall=1
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data hold register
- cpu_stall  out  1  controller must not advance while high
- mem_req  out  1  registered request
- mem_we  out  1  registered: 1 = write
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  memory acknowledge (one cycle)
- mem_rdata  in  DATA_W  valid in the mem_ack cycle
- fault  out  2  sticky: 00 none, 01 misaligned, 10 timeout
- fault_clr  in  1  clears fault

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - If cpu_rd|cpu_wr and cpu_addr[1:0]==0: latch address and data into mem_addr/mem_wdata, set mem_we=cpu_wr, set mem_req=1, then go to WAIT.
  - If cpu_rd|cpu_wr and cpu_addr[1:0]!=0: no memory request; set fault=01 unless already nonzero; go to DONE.
  - If both cpu_rd and cpu_wr are high, the access is treated as a write.
- WAIT:
  - mem_req stays 1 and all mem_* outputs are stable. The wait counter starts at 0 and increments each cycle without ack.
  - If mem_ack: mem_req←0. For a read, cpu_rdata←mem_rdata. Go to DONE.
  - If no ack and the counter equals TIMEOUT-1: mem_req←0, fault=10 unless already nonzero, go to DONE.
  - Ack on that final cycle takes priority over timeout.
- DONE: one cycle, then IDLE unconditionally. Request levels seen in DONE are ignored, so the held request is not reissued.
- Ack in IDLE or DONE is ignored.
- cpu_rdata changes only on an acked read; it holds across writes, faults and timeouts.
- fault:
  - Sticky; only the first fault is recorded.
  - fault_clr zeroes it. When fault_clr and a new fault occur in the same cycle, the new fault is stored.
- cpu_stall is combinational:
  - IDLE: cpu_rd|cpu_wr
  - WAIT: 1
  - DONE: 0

## Timing
- Reset (asynchronous, immediate): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata, fault and counter = 0. cpu_stall follows from IDLE.
- Reset mid-transaction drops mem_req at once. Any later ack is ignored.
- Request sampled in IDLE at cycle T: mem_req is high from T+1.
- Ack at cycle T+1+k (k ≥ 0): DONE at T+2+k, cpu_rdata valid from T+2+k, cpu_stall low in T+2+k.
  - Total stall is k+2 cycles.
  - A back-to-back request is accepted in IDLE at T+3+k at the earliest.
- Misaligned access: DONE at T+1, one stall cycle, mem_req never rises.
- Timeout: mem_req is high for exactly TIMEOUT cycles, DONE follows, and fault=10 is visible in DONE.
- All registered outputs change only on the rising clk edge, except on reset.

## Structure
- Package MemPortPkg holds:
  - state enum {IDLE, WAIT, DONE}
  - fault codes FaultNone=2'b00, FaultMisalign=2'b01, FaultTimeout=2'b10
- Sub-module mem_timeout_ctr:
  - Counter width $clog2(TIMEOUT).
  - Inputs: clear (IDLE→WAIT) and enable (WAIT & !mem_ack).
  - Output: expire (count==TIMEOUT-1).
- The top level holds the FSM, the request registers, cpu_rdata and fault.

## Test plan
- Read, ack after 3 WAIT cycles: cpu_rd=1, addr=0x100, mem_rdata=0xDEADBEEF. Expect mem_req high for 3 cycles, cpu_stall high for 4 cycles, cpu_rdata=0xDEADBEEF in DONE, mem_we=0.
- Write, ack in the first WAIT cycle: cpu_wr=1, addr=0x204, wdata=0x12345678. Expect mem_we=1, mem_wdata=0x12345678, 2 stall cycles, cpu_rdata unchanged.
- Misaligned read at 0x102: mem_req never rises, 1 stall cycle, fault=01. A following timeout still leaves fault=01. fault_clr returns it to 00.
- Timeout with TIMEOUT=4 and no ack: mem_req high for exactly 4 cycles, fault=10. A late ack in DONE or IDLE does not change cpu_rdata.
- Ack on the last allowed cycle (TIMEOUT=4, ack in the 4th WAIT cycle): data captured, fault stays 00.
- Reset asserted mid-WAIT, then the request reissued with ack 1 cycle after reset release: all outputs go to 0 immediately. The new transaction completes normally with no reissue of the old request.
